// File: rtl/trace_pkg.sv
// Shared types and constants for the flopr trace recorder.
//
// Contents:
//   trace_state_t - recorder FSM states (idle / capture / drain)
//   trace_rec_t   - one captured record {rst, d, q, stamp}, sized from the
//                   default TRACE_WIDTH / TRACE_STAMP_W
//   REC_*         - bit offsets of each field inside a packed record, so a
//                   consumer can unpack rd_data without the struct
package trace_pkg;

    localparam int unsigned TRACE_WIDTH   = 32;
    localparam int unsigned TRACE_STAMP_W = 8;
    localparam int unsigned TRACE_REC_W   = 1 + 2 * TRACE_WIDTH + TRACE_STAMP_W;

    // Field offsets, LSB first: stamp, q, d, rst.
    localparam int unsigned REC_STAMP_LSB = 0;
    localparam int unsigned REC_Q_LSB     = TRACE_STAMP_W;
    localparam int unsigned REC_D_LSB     = TRACE_STAMP_W + TRACE_WIDTH;
    localparam int unsigned REC_RST_BIT   = TRACE_STAMP_W + 2 * TRACE_WIDTH;

    typedef enum logic [1:0] {
        StIdle,
        StCapture,
        StDrain
    } trace_state_t;

    typedef struct packed {
        logic                     rst;
        logic [TRACE_WIDTH-1:0]   d;
        logic [TRACE_WIDTH-1:0]   q;
        logic [TRACE_STAMP_W-1:0] stamp;
    } trace_rec_t;

endpackage

// File: rtl/trace_ram.sv
// Record buffer for the trace recorder: DEPTH x REC_W array with a
// synchronous write port and an asynchronous (combinational) read port.
// Contents are not reset.
//
// Ports:
//   clk   - write clock
//   we    - write enable
//   waddr - write address
//   wdata - record to store
//   raddr - read address
//   rdata - record at raddr, combinational
module trace_ram #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned REC_W = 73
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [REC_W-1:0]         wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [REC_W-1:0]         rdata
);

    logic [REC_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/flopr_trace_recorder.sv
// Cycle trace recorder for a watched data-path register. When armed it
// captures {smp_rst, smp_d, smp_q, stamp} every clock into a buffer, then
// streams the records out oldest first over a valid/ready port.
//
// Build option: define TRACE_WRAP_EN to make capture circular (runs until
// stop, keeps the newest DEPTH records, flags overflow). Without it capture
// ends when the buffer fills and overflow is tied to 0.
//
// Ports:
//   clk      - clock, rising edge
//   reset    - asynchronous active-low reset
//   arm      - start capture (sampled in idle only)
//   stop     - end capture early (sampled in capture only)
//   smp_rst  - watched register's reset
//   smp_d    - watched register's d
//   smp_q    - watched register's q
//   rd_valid - a record is presented
//   rd_ready - consumer accepts the record
//   rd_data  - record {smp_rst, smp_d, smp_q, stamp}, 0 while !rd_valid
//   count    - records stored and not yet read
//   busy     - recorder is not idle
//   overflow - records were overwritten (wrap build only)
module flopr_trace_recorder
    import trace_pkg::*;
#(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned DEPTH   = 16,
    parameter int unsigned STAMP_W = 8,
    parameter int unsigned REC_W   = 1 + 2 * WIDTH + STAMP_W
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   arm,
    input  logic                   stop,
    input  logic                   smp_rst,
    input  logic [WIDTH-1:0]       smp_d,
    input  logic [WIDTH-1:0]       smp_q,
    output logic                   rd_valid,
    input  logic                   rd_ready,
    output logic [REC_W-1:0]       rd_data,
    output logic [$clog2(DEPTH):0] count,
    output logic                   busy,
    output logic                   overflow
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    trace_state_t       state_q, state_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [STAMP_W-1:0] stamp_q, stamp_d;
`ifdef TRACE_WRAP_EN
    logic               overflow_q, overflow_d;
`endif

    logic               wr_en;
    logic [REC_W-1:0]   wr_rec;
    logic [REC_W-1:0]   rd_rec;
    logic               rec_avail;
    logic               rd_fire;

    assign wr_en     = (state_q == StCapture);
    assign wr_rec    = {smp_rst, smp_d, smp_q, stamp_q};
    assign rec_avail = (state_q == StDrain) && (count_q != '0);
    assign rd_fire   = rec_avail && rd_ready;

    trace_ram #(
        .DEPTH (DEPTH),
        .REC_W (REC_W)
    ) u_ram (
        .clk   (clk),
        .we    (wr_en),
        .waddr (wr_ptr_q),
        .wdata (wr_rec),
        .raddr (rd_ptr_q),
        .rdata (rd_rec)
    );

    // ------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM next state
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (arm) begin
                    state_d = StCapture;
                end
            end
            StCapture: begin
`ifdef TRACE_WRAP_EN
                if (stop) begin
                    state_d = StDrain;
                end
`else
                // This cycle's write fills the buffer.
                if (stop || (count_q == CNT_FULL - CNT_W'(1))) begin
                    state_d = StDrain;
                end
`endif
            end
            StDrain: begin
                // Empty on entry is unreachable without wrap, kept as an escape.
                if (count_q == '0) begin
                    state_d = StIdle;
                end else if (rd_ready && (count_q == CNT_W'(1))) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // ------------------------------------------------------------------
    // Pointers, count, stamp
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            stamp_q    <= '0;
`ifdef TRACE_WRAP_EN
            overflow_q <= 1'b0;
`endif
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            stamp_q    <= stamp_d;
`ifdef TRACE_WRAP_EN
            overflow_q <= overflow_d;
`endif
        end
    end

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        stamp_d    = stamp_q;
`ifdef TRACE_WRAP_EN
        overflow_d = overflow_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (arm) begin
                    wr_ptr_d   = '0;
                    rd_ptr_d   = '0;
                    count_d    = '0;
                    stamp_d    = '0;
`ifdef TRACE_WRAP_EN
                    overflow_d = 1'b0;
`endif
                end
            end
            StCapture: begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
                stamp_d  = stamp_q + STAMP_W'(1);
                if (count_q != CNT_FULL) begin
                    count_d = count_q + CNT_W'(1);
                end
`ifdef TRACE_WRAP_EN
                else begin
                    // Full: this write lands on the oldest record, drop it.
                    rd_ptr_d   = rd_ptr_q + PTR_W'(1);
                    overflow_d = 1'b1;
                end
`endif
            end
            StDrain: begin
                if (rd_fire) begin
                    rd_ptr_d = rd_ptr_q + PTR_W'(1);
                    count_d  = count_q - CNT_W'(1);
                end
            end
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    always_comb begin
        rd_valid = rec_avail;
        rd_data  = rec_avail ? rd_rec : '0;
        busy     = (state_q != StIdle);
        count    = count_q;
    end

`ifdef TRACE_WRAP_EN
    assign overflow = overflow_q;
`else
    assign overflow = 1'b0;
`endif

endmodule

// File: tb/tb_flopr_trace_recorder.sv
module tb_flopr_trace_recorder;
    import trace_pkg::*;

    logic                   clk;
    logic                   reset;
    logic                   arm;
    logic                   stop;
    logic                   smp_rst;
    logic [TRACE_WIDTH-1:0] smp_d;
    logic [TRACE_WIDTH-1:0] smp_q;
    logic                   rd_valid;
    logic                   rd_ready;
    logic [TRACE_REC_W-1:0] rd_data;
    logic [4:0]             count;
    logic                   busy;
    logic                   overflow;

    int checks   = 0;
    int failures = 0;

    flopr_trace_recorder #(
        .WIDTH   (TRACE_WIDTH),
        .DEPTH   (16),
        .STAMP_W (TRACE_STAMP_W)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .arm      (arm),
        .stop     (stop),
        .smp_rst  (smp_rst),
        .smp_d    (smp_d),
        .smp_q    (smp_q),
        .rd_valid (rd_valid),
        .rd_ready (rd_ready),
        .rd_data  (rd_data),
        .count    (count),
        .busy     (busy),
        .overflow (overflow)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL timeout: bench still running at %0t", $time);
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic check_rec(input string tag, input logic rst, input logic [31:0] d,
                             input logic [31:0] q, input logic [7:0] st);
        trace_rec_t r;
        r = rd_data;
        check_eq({tag, ".valid"}, rd_valid, 1);
        check_eq({tag, ".rst"}, rd_data[REC_RST_BIT], rst);
        check_eq({tag, ".d"}, r.d, d);
        check_eq({tag, ".q"}, r.q, q);
        check_eq({tag, ".stamp"}, r.stamp, st);
    endtask

    initial begin
        reset    = 1'b0;
        arm      = 1'b0;
        stop     = 1'b0;
        smp_rst  = 1'b0;
        smp_d    = '0;
        smp_q    = '0;
        rd_ready = 1'b1;
        #1;
        check_eq("rst.busy", busy, 0);
        check_eq("rst.count", count, 0);
        check_eq("rst.valid", rd_valid, 0);
        check_eq("rst.data", rd_data[63:0], 0);
        check_eq("rst.overflow", overflow, 0);
        tick();
        reset = 1'b1;
        tick();

        // Full capture without stop: d=k, q=k-1, stamps 0..15.
        arm = 1'b1;
        tick();
        arm = 1'b0;
        check_eq("t1.busy_arm", busy, 1);
        check_eq("t1.count_arm", count, 0);
        for (int k = 1; k <= 16; k++) begin
            smp_d = k;
            smp_q = k - 1;
            tick();
        end
        check_eq("t1.count_full", count, 16);
        for (int i = 0; i < 16; i++) begin
            check_rec($sformatf("t1.rec%0d", i), 0, i + 1, i, i);
            check_eq("t1.busy_drain", busy, 1);
            tick();
        end
        check_eq("t1.busy_end", busy, 0);
        check_eq("t1.count_end", count, 0);
        check_eq("t1.valid_end", rd_valid, 0);
        check_eq("t1.data_end", rd_data[63:0], 0);
        check_eq("t1.overflow", overflow, 0);

        // Early stop on the third capture cycle.
        arm = 1'b1;
        tick();
        arm = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            smp_d = 100 + k;
            smp_q = 50 + k;
            stop  = (k == 3);
            tick();
        end
        stop = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check_eq("t2.count", count, 3 - i);
            check_rec($sformatf("t2.rec%0d", i), 0, 101 + i, 51 + i, i);
            tick();
        end
        check_eq("t2.count_end", count, 0);
        check_eq("t2.busy_end", busy, 0);

        // Stop in idle is ignored; arm in capture/drain is ignored; backpressure.
        rd_ready = 1'b0;
        stop = 1'b1;
        tick();
        stop = 1'b0;
        check_eq("t3.stop_idle_busy", busy, 0);
        arm = 1'b1;
        tick();
        arm = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            smp_rst = (k % 2 == 1);
            smp_d   = 200 + k;
            smp_q   = k * 3;
            arm     = (k == 2);
            stop    = (k == 4);
            tick();
        end
        arm  = 1'b0;
        stop = 1'b0;
        check_eq("t3.count_cap", count, 4);
        for (int c = 0; c < 5; c++) begin
            arm  = (c == 1);
            stop = (c == 2);
            check_rec($sformatf("t3.hold%0d", c), 1, 201, 3, 0);
            check_eq("t3.count_hold", count, 4);
            tick();
        end
        arm  = 1'b0;
        stop = 1'b0;
        rd_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check_rec($sformatf("t3.rec%0d", i), ((i + 1) % 2 == 1), 201 + i, (i + 1) * 3, i);
            tick();
        end
        check_eq("t3.busy_end", busy, 0);

        // Arm right after the last handshake, then reset mid-capture.
        smp_rst = 1'b0;
        arm = 1'b1;
        tick();
        arm = 1'b0;
        check_eq("t4.busy_rearm", busy, 1);
        for (int k = 1; k <= 7; k++) begin
            smp_d = 300 + k;
            tick();
        end
        check_eq("t4.count7", count, 7);
        #2;
        reset = 1'b0;
        #1;
        check_eq("t4.rst_busy", busy, 0);
        check_eq("t4.rst_count", count, 0);
        check_eq("t4.rst_valid", rd_valid, 0);
        tick();
        reset = 1'b1;
        tick();
        arm = 1'b1;
        tick();
        arm = 1'b0;
        for (int k = 1; k <= 2; k++) begin
            smp_d = 400 + k;
            smp_q = 7;
            stop  = (k == 2);
            tick();
        end
        stop = 1'b0;
        for (int i = 0; i < 2; i++) begin
            check_rec($sformatf("t4.rec%0d", i), 0, 401 + i, 7, i);
            tick();
        end
        check_eq("t4.busy_end", busy, 0);

`ifdef TRACE_WRAP_EN
        // Circular capture of 20 records keeps the newest 16.
        arm = 1'b1;
        tick();
        arm = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            smp_d = 500 + k;
            smp_q = k;
            stop  = (k == 20);
            tick();
            if (k == 16) begin
                check_eq("t5.ovf16", overflow, 0);
                check_eq("t5.count16", count, 16);
            end
            if (k == 17) begin
                check_eq("t5.ovf17", overflow, 1);
                check_eq("t5.count17", count, 16);
            end
        end
        stop = 1'b0;
        check_eq("t5.count_stop", count, 16);
        for (int i = 0; i < 16; i++) begin
            check_rec($sformatf("t5.rec%0d", i), 0, 505 + i, 5 + i, 4 + i);
            tick();
        end
        check_eq("t5.busy_end", busy, 0);
        check_eq("t5.ovf_sticky", overflow, 1);
        arm = 1'b1;
        tick();
        arm = 1'b0;
        check_eq("t5.ovf_clear", overflow, 0);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        tick();
        check_eq("t5.busy_final", busy, 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
